// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipeline_pkg;

  localparam int unsigned RF_SIZE = 5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    DRAIN = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic pc_we;
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic flush_id;
    logic flush_ex;
    logic bubble_wb;
  } stage_ctrl_t;

  // Whole-pipe hold while data memory is outstanding.
  function automatic stage_ctrl_t freeze_ctrl();
    stage_ctrl_t c;
    c           = '0;
    c.stall_if  = 1'b1;
    c.stall_id  = 1'b1;
    c.stall_ex  = 1'b1;
    c.bubble_wb = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use hazard term: ID reads a non-x0 register that the EX load will write.
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic               EnMemR_ex,
  input  logic               EnRd_ex,
  input  logic [RF_SIZE-1:0] RdIdx_ex,
  input  logic [RF_SIZE-1:0] Rs1Idx_id,
  input  logic [RF_SIZE-1:0] Rs2Idx_id,
  output logic               lu_c
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = (Rs1Idx_id == RdIdx_ex) && (Rs1Idx_id != '0);
  assign rs2_hit = (Rs2Idx_id == RdIdx_ex) && (Rs2Idx_id != '0);
  assign lu_c    = EnMemR_ex && EnRd_ex && (RdIdx_ex != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with saturating hazard counters.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               EnMemR_ex,
  input  logic               EnRd_ex,
  input  logic [RF_SIZE-1:0] RdIdx_ex,
  input  logic [RF_SIZE-1:0] Rs1Idx_id,
  input  logic [RF_SIZE-1:0] Rs2Idx_id,
  input  logic               redirect_ex,
  input  logic               imem_busy,
  input  logic               imem_ready,
  input  logic               dmem_req_mem,
  input  logic               dmem_ready,
  output logic               pc_we,
  output logic               stall_if,
  output logic               stall_id,
  output logic               stall_ex,
  output logic               flush_id,
  output logic               flush_ex,
  output logic               bubble_wb,
  output logic [CNT_W-1:0]   lu_cnt,
  output logic [CNT_W-1:0]   dwait_cnt
);

  ctrl_state_e state_q, state_d;
  logic        drained_q, drained_d;
  logic [CNT_W-1:0] lu_q, dwait_q;

  logic        lu;
  logic        dfail;
  stage_ctrl_t run_ctrl;
  logic        run_lu;
  stage_ctrl_t ctrl;
  logic        lu_take;
  logic        freeze;

  load_use_detect u_lu (
    .EnMemR_ex (EnMemR_ex),
    .EnRd_ex   (EnRd_ex),
    .RdIdx_ex  (RdIdx_ex),
    .Rs1Idx_id (Rs1Idx_id),
    .Rs2Idx_id (Rs2Idx_id),
    .lu_c      (lu)
  );

  assign dfail = dmem_req_mem && !dmem_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      drained_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      drained_q <= drained_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    drained_d = drained_q;
    case (state_q)
      RUN: begin
        if (dfail) begin
          state_d = DWAIT;
        end else if (redirect_ex && imem_busy && !imem_ready) begin
          state_d = DRAIN;
        end
      end
      DWAIT: begin
        if (!dfail) begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (dfail) begin
          drained_d = drained_q || imem_ready;
        end else if (drained_q || imem_ready) begin
          state_d   = RUN;
          drained_d = 1'b0;
        end
      end
      default: begin
        state_d   = RUN;
        drained_d = 1'b0;
      end
    endcase
  end

  // Unfrozen priority: redirect, then load-use, then fetch wait.
  always_comb begin
    run_ctrl = '0;
    run_lu   = 1'b0;
    if (redirect_ex) begin
      run_ctrl.flush_id = 1'b1;
      run_ctrl.flush_ex = 1'b1;
      run_ctrl.pc_we    = 1'b1;
    end else if (lu) begin
      run_ctrl.stall_if = 1'b1;
      run_ctrl.stall_id = 1'b1;
      run_ctrl.flush_ex = 1'b1;
      run_lu            = 1'b1;
    end else if (!imem_ready) begin
      run_ctrl.stall_if = 1'b1;
      run_ctrl.flush_id = 1'b1;
    end else begin
      run_ctrl.pc_we = 1'b1;
    end
  end

  // Output decode; a data-memory miss overrides everything but reset.
  always_comb begin
    ctrl    = '0;
    lu_take = 1'b0;
    freeze  = 1'b0;
    if (rst) begin
      ctrl.flush_id  = 1'b1;
      ctrl.flush_ex  = 1'b1;
      ctrl.bubble_wb = 1'b1;
    end else if (dfail) begin
      ctrl   = freeze_ctrl();
      freeze = 1'b1;
    end else if (state_q == DRAIN) begin
      ctrl.stall_if = 1'b1;
      ctrl.flush_id = 1'b1;
    end else begin
      ctrl    = run_ctrl;
      lu_take = run_lu;
    end
  end

  assign pc_we     = ctrl.pc_we;
  assign stall_if  = ctrl.stall_if;
  assign stall_id  = ctrl.stall_id;
  assign stall_ex  = ctrl.stall_ex;
  assign flush_id  = ctrl.flush_id;
  assign flush_ex  = ctrl.flush_ex;
  assign bubble_wb = ctrl.bubble_wb;

  // Saturating perf counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_q    <= '0;
      dwait_q <= '0;
    end else begin
      if (lu_take && !(&lu_q)) begin
        lu_q <= lu_q + CNT_W'(1);
      end
      if (freeze && !(&dwait_q)) begin
        dwait_q <= dwait_q + CNT_W'(1);
      end
    end
  end

  assign lu_cnt    = lu_q;
  assign dwait_cnt = dwait_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed and random checks of pipeline_ctrl against a rule-level reference model.
module tb_pipeline_ctrl;

  localparam int unsigned CW = 6;
  localparam logic [CW-1:0] CMAX = '1;

  logic clk = 1'b0;
  logic rst;
  logic EnMemR_ex, EnRd_ex;
  logic [4:0] RdIdx_ex, Rs1Idx_id, Rs2Idx_id;
  logic redirect_ex, imem_busy, imem_ready, dmem_req_mem, dmem_ready;
  logic pc_we, stall_if, stall_id, stall_ex, flush_id, flush_ex, bubble_wb;
  logic [CW-1:0] lu_cnt, dwait_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: is a memory wait pending, is a stale fetch being drained.
  bit m_mem_wait;
  bit m_draining;
  bit m_stale_seen;
  logic [CW-1:0] m_lu;
  logic [CW-1:0] m_dw;

  // Control vector order: pc_we stall_if stall_id stall_ex flush_id flush_ex bubble_wb
  localparam logic [6:0] C_RST    = 7'b0000111;
  localparam logic [6:0] C_FREEZE = 7'b0111001;
  localparam logic [6:0] C_REDIR  = 7'b1000110;
  localparam logic [6:0] C_LU     = 7'b0110010;
  localparam logic [6:0] C_IWAIT  = 7'b0100100;
  localparam logic [6:0] C_GO     = 7'b1000000;

  pipeline_ctrl #(.CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .EnMemR_ex    (EnMemR_ex),
    .EnRd_ex      (EnRd_ex),
    .RdIdx_ex     (RdIdx_ex),
    .Rs1Idx_id    (Rs1Idx_id),
    .Rs2Idx_id    (Rs2Idx_id),
    .redirect_ex  (redirect_ex),
    .imem_busy    (imem_busy),
    .imem_ready   (imem_ready),
    .dmem_req_mem (dmem_req_mem),
    .dmem_ready   (dmem_ready),
    .pc_we        (pc_we),
    .stall_if     (stall_if),
    .stall_id     (stall_id),
    .stall_ex     (stall_ex),
    .flush_id     (flush_id),
    .flush_ex     (flush_ex),
    .bubble_wb    (bubble_wb),
    .lu_cnt       (lu_cnt),
    .dwait_cnt    (dwait_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CMAX) ? v : v + CW'(1);
  endfunction

  // Check this cycle's outputs against the model, then advance the model one clock.
  task automatic tick(input string tag);
    logic [6:0] exp;
    bit hz;
    bit miss;
    bit was_waiting;
    #1;
    hz = EnMemR_ex && EnRd_ex && RdIdx_ex != 0 &&
         ((Rs1Idx_id == RdIdx_ex && Rs1Idx_id != 0) || (Rs2Idx_id == RdIdx_ex && Rs2Idx_id != 0));
    miss = dmem_req_mem && !dmem_ready;
    chk({tag, ":lu_cnt"}, 64'(lu_cnt), 64'(m_lu));
    chk({tag, ":dwait_cnt"}, 64'(dwait_cnt), 64'(m_dw));
    if (rst) begin
      exp = C_RST;
      m_mem_wait = 0; m_draining = 0; m_stale_seen = 0; m_lu = '0; m_dw = '0;
    end else if (miss) begin
      exp = C_FREEZE;
      m_dw = sat_inc(m_dw);
      if (m_draining) m_stale_seen = m_stale_seen || imem_ready;
      else m_mem_wait = 1;
    end else if (m_draining) begin
      exp = C_IWAIT;
      if (m_stale_seen || imem_ready) begin
        m_draining = 0; m_stale_seen = 0;
      end
    end else begin
      was_waiting = m_mem_wait;
      m_mem_wait = 0;
      if (redirect_ex) begin
        exp = C_REDIR;
        if (!was_waiting && imem_busy && !imem_ready) m_draining = 1;
      end else if (hz) begin
        exp = C_LU;
        m_lu = sat_inc(m_lu);
      end else if (!imem_ready) begin
        exp = C_IWAIT;
      end else begin
        exp = C_GO;
      end
    end
    chk({tag, ":ctrl"}, 64'({pc_we, stall_if, stall_id, stall_ex, flush_id, flush_ex, bubble_wb}),
        64'(exp));
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; EnMemR_ex = 0; EnRd_ex = 0; RdIdx_ex = 0; Rs1Idx_id = 0; Rs2Idx_id = 0;
    redirect_ex = 0; imem_busy = 0; imem_ready = 1; dmem_req_mem = 0; dmem_ready = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    m_mem_wait = 0; m_draining = 0; m_stale_seen = 0; m_lu = '0; m_dw = '0;
    @(negedge clk);
    tick("reset0");
    tick("reset1");
    idle();
    tick("run");

    // Load-use on rs2 gives exactly one bubble.
    EnMemR_ex = 1; EnRd_ex = 1; RdIdx_ex = 5; Rs2Idx_id = 5;
    tick("lu");
    idle();
    tick("lu_after");

    // x0 never creates a hazard.
    EnMemR_ex = 1; EnRd_ex = 1; RdIdx_ex = 0; Rs1Idx_id = 0; Rs2Idx_id = 0;
    tick("x0");
    idle();

    // Three-cycle dmem wait with redirect held; redirect acts only on release.
    dmem_req_mem = 1; dmem_ready = 0; redirect_ex = 1;
    tick("dwait1");
    tick("dwait2");
    tick("dwait3");
    dmem_ready = 1;
    tick("dwait_release");
    idle();
    tick("dwait_done");

    // Redirect with fetch in flight, stale response after two cycles.
    redirect_ex = 1; imem_busy = 1; imem_ready = 0;
    tick("redir_drain");
    redirect_ex = 0;
    tick("drain1");
    tick("drain2");
    imem_ready = 1; imem_busy = 0;
    tick("drain_resp");
    tick("drain_exit");

    // Reset while frozen.
    dmem_req_mem = 1; dmem_ready = 0;
    tick("pre_rst_dwait");
    rst = 1;
    tick("rst_in_dwait");
    rst = 0;
    dmem_req_mem = 0;
    tick("post_rst");

    // Drive dwait_cnt to all-ones and beyond.
    dmem_req_mem = 1; dmem_ready = 0;
    for (int i = 0; i < 70; i++) tick("sat");
    idle();
    tick("sat_release");

    // Random traffic with narrow register indices to provoke collisions.
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      EnMemR_ex    = 1'($urandom_range(0, 1));
      EnRd_ex      = 1'($urandom_range(0, 1));
      RdIdx_ex     = 5'($urandom_range(0, 3));
      Rs1Idx_id    = 5'($urandom_range(0, 3));
      Rs2Idx_id    = 5'($urandom_range(0, 3));
      redirect_ex  = ($urandom_range(0, 7) == 0);
      imem_busy    = 1'($urandom_range(0, 1));
      imem_ready   = ($urandom_range(0, 2) != 0);
      dmem_req_mem = ($urandom_range(0, 2) == 0);
      dmem_ready   = 1'($urandom_range(0, 1));
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
